// File: rtl/cdec8_dbgmon.sv
// cdec8_dbgmon: UART debug monitor for the CDEC8 core.
// Decodes single-byte host commands, samples data-path resources and drives CPU run/step.
module cdec8_dbgmon #(
  parameter int unsigned BAUD_DIV = 434
) (
  input  logic       clock,
  input  logic       reset_N,
  input  logic       uart_rx,
  output logic       uart_tx,
  output logic [7:0] resad,
  input  logic [7:0] resdt,
  output logic       cpu_run,
  output logic       cpu_step,
  output logic       busy
);
  localparam int unsigned CW = 16;
  localparam logic [CW-1:0] BIT_LAST  = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(BAUD_DIV / 2 - 1);

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_state_e;
  typedef enum logic [2:0] {E_IDLE, E_SETAD, E_SAMPLE, E_TXBYTE, E_NEXT} eng_state_e;

  logic            rx_meta_q, rx_sync_q, rx_prev_q;
  rx_state_e       rx_state_q, rx_state_d;
  logic [CW-1:0]   rx_cnt_q, rx_cnt_d;
  logic [2:0]      rx_bit_q, rx_bit_d;
  logic [7:0]      rx_shift_q, rx_shift_d;
  logic            rx_valid_q, rx_valid_d;

  eng_state_e      st_q, st_d;
  logic [7:0]      cmd_q, cmd_d;
  logic [7:0]      resad_q, resad_d;
  logic [7:0]      tx_shift_q, tx_shift_d;
  logic [CW-1:0]   tx_cnt_q, tx_cnt_d;
  logic [3:0]      tx_bit_q, tx_bit_d;
  logic            uart_tx_q, uart_tx_d;
  logic            cpu_run_q, cpu_run_d;
  logic            cpu_step_q, cpu_step_d;
  logic            busy_q, busy_d;
  logic            dump_q, dump_d;
  logic            cmd_is_read_c, cmd_is_dump_c;

  assign cmd_is_read_c = (cmd_q[7:4] == 4'h0);
  assign cmd_is_dump_c = (cmd_q == 8'hFF);

  // Receiver: start-bit midpoint check, 8 data bits LSB first, stop-bit validation.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_valid_d = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (rx_prev_q && !rx_sync_q) begin
          rx_cnt_d   = HALF_LAST;
          rx_state_d = RX_START;
        end
      end
      RX_START: begin
        if (rx_cnt_q != '0) begin
          rx_cnt_d = rx_cnt_q - CW'(1);
        end else if (rx_sync_q) begin
          rx_state_d = RX_IDLE;
        end else begin
          rx_cnt_d   = BIT_LAST;
          rx_bit_d   = '0;
          rx_state_d = RX_DATA;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q != '0) begin
          rx_cnt_d = rx_cnt_q - CW'(1);
        end else begin
          rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
          rx_cnt_d   = BIT_LAST;
          rx_bit_d   = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (rx_cnt_q != '0) begin
          rx_cnt_d = rx_cnt_q - CW'(1);
        end else if (rx_sync_q) begin
          rx_valid_d = 1'b1;
          rx_state_d = RX_IDLE;
        end else begin
          rx_state_d = RX_WAIT;
        end
      end
      RX_WAIT: begin
        if (rx_sync_q) rx_state_d = RX_IDLE;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // Command engine and transmitter; bytes arriving outside IDLE are ignored.
  always_comb begin
    st_d       = st_q;
    cmd_d      = cmd_q;
    resad_d    = resad_q;
    tx_shift_d = tx_shift_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    uart_tx_d  = uart_tx_q;
    cpu_run_d  = cpu_run_q;
    cpu_step_d = 1'b0;
    dump_d     = dump_q;
    case (st_q)
      E_IDLE: begin
        if (rx_valid_q) begin
          cmd_d = rx_shift_q;
          st_d  = E_SETAD;
        end
      end
      E_SETAD: begin
        st_d       = E_SAMPLE;
        tx_shift_d = 8'h3F;
        if (cmd_is_read_c) begin
          resad_d = cmd_q;
        end else if (cmd_is_dump_c) begin
          if (!dump_q) resad_d = 8'h00;
          dump_d = 1'b1;
        end else begin
          case (cmd_q)
            8'h80: begin cpu_run_d = 1'b0; tx_shift_d = 8'h80; end
            8'h81: begin cpu_run_d = 1'b1; tx_shift_d = 8'h81; end
            8'h82: begin
              if (!cpu_run_q) begin
                cpu_step_d = 1'b1;
                tx_shift_d = 8'h82;
              end
            end
            default: tx_shift_d = 8'h3F;
          endcase
        end
      end
      E_SAMPLE: begin
        if (cmd_is_read_c || cmd_is_dump_c) tx_shift_d = resdt;
        uart_tx_d = 1'b0;
        tx_cnt_d  = BIT_LAST;
        tx_bit_d  = '0;
        st_d      = E_TXBYTE;
      end
      E_TXBYTE: begin
        if (tx_cnt_q != '0) begin
          tx_cnt_d = tx_cnt_q - CW'(1);
        end else if (tx_bit_q == 4'd9) begin
          if (cmd_is_dump_c && resad_q != 8'h0F) begin
            st_d = E_NEXT;
          end else begin
            st_d   = E_IDLE;
            dump_d = 1'b0;
          end
        end else begin
          tx_cnt_d = BIT_LAST;
          tx_bit_d = tx_bit_q + 4'd1;
          if (tx_bit_q == 4'd8) begin
            uart_tx_d = 1'b1;
          end else begin
            uart_tx_d  = tx_shift_q[0];
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
          end
        end
      end
      E_NEXT: begin
        resad_d = resad_q + 8'd1;
        st_d    = E_SETAD;
      end
      default: st_d = E_IDLE;
    endcase
    busy_d = (st_d != E_IDLE);
  end

  always_ff @(posedge clock or negedge reset_N) begin
    if (!reset_N) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_valid_q <= 1'b0;
      st_q       <= E_IDLE;
      cmd_q      <= '0;
      resad_q    <= '0;
      tx_shift_q <= '0;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      uart_tx_q  <= 1'b1;
      cpu_run_q  <= 1'b1;
      cpu_step_q <= 1'b0;
      busy_q     <= 1'b0;
      dump_q     <= 1'b0;
    end else begin
      rx_meta_q  <= uart_rx;
      rx_sync_q  <= rx_meta_q;
      rx_prev_q  <= rx_sync_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_valid_q <= rx_valid_d;
      st_q       <= st_d;
      cmd_q      <= cmd_d;
      resad_q    <= resad_d;
      tx_shift_q <= tx_shift_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      uart_tx_q  <= uart_tx_d;
      cpu_run_q  <= cpu_run_d;
      cpu_step_q <= cpu_step_d;
      busy_q     <= busy_d;
      dump_q     <= dump_d;
    end
  end

  assign uart_tx  = uart_tx_q;
  assign resad    = resad_q;
  assign cpu_run  = cpu_run_q;
  assign cpu_step = cpu_step_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_cdec8_dbgmon.sv
// tb_cdec8_dbgmon: randomized host-command bench with a transaction-level model of the monitor.
module tb_cdec8_dbgmon;
  localparam int B     = 8;
  localparam int FRAME = 10 * B;
  localparam int SLOT  = FRAME + 3;

  logic       clock = 1'b0;
  logic       reset_N;
  logic       uart_rx;
  logic       uart_tx;
  logic [7:0] resad;
  logic [7:0] resdt;
  logic       cpu_run;
  logic       cpu_step;
  logic       busy;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int start_cyc = 0;

  logic       m_run;
  logic [7:0] m_resad;
  logic [7:0] got_q[$];

  cdec8_dbgmon #(.BAUD_DIV(B)) dut (
    .clock    (clock),
    .reset_N  (reset_N),
    .uart_rx  (uart_rx),
    .uart_tx  (uart_tx),
    .resad    (resad),
    .resdt    (resdt),
    .cpu_run  (cpu_run),
    .cpu_step (cpu_step),
    .busy     (busy)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Data-path observation port: each resource reads back as its address + 0x40.
  assign resdt = resad + 8'h40;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] last_got(input int back);
    if (got_q.size() > back) return got_q[got_q.size() - 1 - back];
    return 8'hxx;
  endfunction

  task automatic send_frame(input logic [7:0] d, input logic stop);
    @(negedge clock);
    start_cyc = cyc;
    uart_rx = 1'b0;
    repeat (B) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      uart_rx = d[i];
      repeat (B) @(negedge clock);
    end
    uart_rx = stop;
    repeat (B) @(negedge clock);
    uart_rx = 1'b1;
  endtask

  // Nothing may happen on the outputs for the given number of cycles.
  task automatic check_silent(input string name, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clock);
      chk({name, "_busy"}, 32'(busy), 32'd0);
      chk({name, "_tx"}, 32'(uart_tx), 32'd1);
      chk({name, "_step"}, 32'(cpu_step), 32'd0);
      chk({name, "_run"}, 32'(cpu_run), 32'(m_run));
      chk({name, "_resad"}, 32'(resad), 32'(m_resad));
    end
  endtask

  // Model of one accepted command, compared against the outputs every cycle.
  task automatic check_cmd(input logic [7:0] cmd, input int reset_at);
    logic [7:0] bytes[$];
    logic [7:0] addr_of[$];
    logic       old_run, run_new, pulse, is_read, is_dump, found;
    logic       exp_tx;
    logic [7:0] old_resad, new_resad, cap, cb;
    int         nb, c_end, bi, off, k, lat;
    old_resad = m_resad;
    old_run   = m_run;
    run_new   = m_run;
    new_resad = m_resad;
    pulse     = 1'b0;
    is_read   = (cmd < 8'h10);
    is_dump   = (cmd == 8'hFF);
    if (is_read) begin
      bytes.push_back(cmd + 8'h40);
      addr_of.push_back(cmd);
      new_resad = cmd;
    end else if (is_dump) begin
      for (int a = 0; a < 16; a++) begin
        bytes.push_back(8'(a) + 8'h40);
        addr_of.push_back(8'(a));
      end
      new_resad = 8'h0F;
    end else begin
      if (cmd == 8'h80) begin run_new = 1'b0; bytes.push_back(8'h80); end
      else if (cmd == 8'h81) begin run_new = 1'b1; bytes.push_back(8'h81); end
      else if (cmd == 8'h82 && !m_run) begin pulse = 1'b1; bytes.push_back(8'h82); end
      else bytes.push_back(8'h3F);
      addr_of.push_back(m_resad);
    end
    nb    = bytes.size();
    c_end = 2 + (nb - 1) * SLOT + FRAME;

    found = 1'b0;
    for (int i = 0; i < 12 * B && !found; i++) begin
      @(negedge clock);
      if (busy === 1'b1) found = 1'b1;
    end
    chk("busy_rise", 32'(found), 32'd1);
    if (!found) return;
    lat = cyc - start_cyc;
    chk("cmd_latency", 32'(lat >= 9 * B + B / 2 && lat <= 10 * B + 2), 32'd1);

    cap = 8'h00;
    for (int c = 0; c <= c_end + 2; c++) begin
      if (c > 0) @(negedge clock);
      if (c == reset_at) begin
        reset_N = 1'b0;
        #1;
        chk("rst_tx", 32'(uart_tx), 32'd1);
        chk("rst_resad", 32'(resad), 32'h00);
        chk("rst_run", 32'(cpu_run), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_step", 32'(cpu_step), 32'd0);
        m_run = 1'b1;
        m_resad = 8'h00;
        repeat (2) @(negedge clock);
        reset_N = 1'b1;
        return;
      end
      exp_tx = 1'b1;
      bi = -1;
      off = 0;
      k = 0;
      if (c >= 2) begin
        bi  = (c - 2) / SLOT;
        off = (c - 2) % SLOT;
        if (bi >= nb || off >= FRAME) bi = -1;
      end
      if (bi >= 0) begin
        k  = off / B;
        cb = bytes[bi];
        if (k == 0) exp_tx = 1'b0;
        else if (k <= 8) exp_tx = cb[k-1];
        if (k >= 1 && k <= 8 && (off % B) == B / 2) begin
          cap[k-1] = uart_tx;
          if (k == 8) got_q.push_back(cap);
        end
        chk("resad_frame", 32'(resad), 32'(addr_of[bi]));
      end
      chk("uart_tx", 32'(uart_tx), 32'(exp_tx));
      chk("busy", 32'(busy), 32'(c < c_end));
      chk("cpu_run", 32'(cpu_run), 32'((c == 0) ? old_run : run_new));
      chk("cpu_step", 32'(cpu_step), 32'(pulse && c == 1));
      if (c == 0) chk("resad_pre", 32'(resad), 32'(old_resad));
      if (c == 1 && (is_read || is_dump)) chk("resad_set", 32'(resad), 32'(addr_of[0]));
      if (c >= c_end) chk("resad_hold", 32'(resad), 32'(new_resad));
    end
    m_run   = run_new;
    m_resad = new_resad;
  endtask

  task automatic run_cmd(input logic [7:0] cmd);
    fork
      send_frame(cmd, 1'b1);
      check_cmd(cmd, -1);
    join
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] rc;
    int sel;
    reset_N = 1'b0;
    uart_rx = 1'b1;
    m_run   = 1'b1;
    m_resad = 8'h00;
    repeat (3) @(negedge clock);
    chk("reset_tx", 32'(uart_tx), 32'd1);
    chk("reset_resad", 32'(resad), 32'h00);
    chk("reset_run", 32'(cpu_run), 32'd1);
    chk("reset_step", 32'(cpu_step), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    reset_N = 1'b1;
    repeat (4) @(negedge clock);

    run_cmd(8'h03);
    chk("read03_byte", 32'(last_got(0)), 32'h43);
    chk("read03_resad", 32'(resad), 32'h03);

    run_cmd(8'h80);
    chk("halt_echo", 32'(last_got(0)), 32'h80);
    chk("halt_run", 32'(cpu_run), 32'd0);
    run_cmd(8'h82);
    chk("step_echo", 32'(last_got(0)), 32'h82);
    run_cmd(8'h81);
    chk("run_echo", 32'(last_got(0)), 32'h81);
    chk("run_run", 32'(cpu_run), 32'd1);
    run_cmd(8'h82);
    chk("step_running_echo", 32'(last_got(0)), 32'h3F);

    // DUMP with a byte arriving mid-dump that must be ignored.
    fork
      send_frame(8'hFF, 1'b1);
      check_cmd(8'hFF, -1);
      begin
        repeat (300) @(negedge clock);
        send_frame(8'h05, 1'b1);
      end
    join
    chk("dump_first", 32'(last_got(15)), 32'h40);
    chk("dump_last", 32'(last_got(0)), 32'h4F);
    chk("dump_resad", 32'(resad), 32'h0F);
    check_silent("after_dump", 4 * B);

    fork
      send_frame(8'h55, 1'b0);
      check_silent("framing", 12 * B);
    join
    run_cmd(8'h01);
    chk("read01_byte", 32'(last_got(0)), 32'h41);

    @(negedge clock);
    uart_rx = 1'b0;
    repeat (2) @(negedge clock);
    uart_rx = 1'b1;
    check_silent("glitch", 12 * B);

    run_cmd(8'h80);
    fork
      send_frame(8'hFF, 1'b1);
      check_cmd(8'hFF, 2 + 4 * SLOT + 3 * B);
    join
    repeat (2) @(negedge clock);
    run_cmd(8'h02);
    chk("read02_byte", 32'(last_got(0)), 32'h42);

    for (int n = 0; n < 25; n++) begin
      sel = int'($urandom_range(0, 9));
      if (sel <= 2) rc = 8'($urandom_range(0, 15));
      else if (sel == 3) rc = 8'h80;
      else if (sel == 4) rc = 8'h81;
      else if (sel <= 6) rc = 8'h82;
      else if (sel <= 8) begin
        rc = 8'($urandom_range(16, 254));
        while (rc == 8'h80 || rc == 8'h81 || rc == 8'h82) rc = 8'($urandom_range(16, 254));
      end else rc = 8'hFF;
      run_cmd(rc);
      repeat ($urandom_range(0, 5)) @(negedge clock);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
